// File: rtl/clk_align_fsm.sv
// ECLKSYNC phase aligner: slips the divider with eclk_stop pulses until a filtered 00 -> 01
// phase transition is seen. Define CLK_ALIGN_RELOCK_EN to keep watching the phase after lock.
module clk_align_fsm #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned FILTER_LEN    = 8,
    parameter int unsigned STOP_CYCLES   = 4,
    parameter int unsigned MAX_TRIES     = 15
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic [1:0] align_status,
    input  logic       restart,
    output logic       eclk_stop,
    output logic       lock,
    output logic       fail,
    output logic [3:0] tries
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > STOP_CYCLES) ? SETTLE_CYCLES : STOP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned RunW   = $clog2(FILTER_LEN + 1);

    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] StopLast   = CntW'(STOP_CYCLES - 1);
    localparam logic [RunW-1:0] RunFull    = RunW'(FILTER_LEN);
    localparam logic [3:0]      TriesMax   = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        StSettle,
        StSample,
        StStop,
        StLocked,
        StFail
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RunW-1:0] run_q, run_d;
    logic [RunW-1:0] run_nxt;
    logic [1:0]      s_q, s_prev_q;
    logic [1:0]      prev_f_q, prev_f_d;
    logic [3:0]      tries_q, tries_d;
    logic [3:0]      tries_inc;
    logic            stop_q, stop_d;
    logic            lock_q, lock_d;
    logic            fail_q, fail_d;
    logic            filt_ok;

    // Run length of identical samples; held at FILTER_LEN so a steady input keeps qualifying.
    always_comb begin
        run_nxt = RunW'(1);
        if (s_q == s_prev_q) begin
            run_nxt = (run_q == RunFull) ? RunFull : run_q + 1'b1;
        end
        filt_ok   = (run_nxt == RunFull);
        tries_inc = (tries_q == 4'hf) ? 4'hf : tries_q + 4'd1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        prev_f_d = prev_f_q;
        tries_d  = tries_q;

        unique case (state_q)
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StSample;
                    cnt_d   = '0;
                    run_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSample: begin
                run_d = run_nxt;
                if (filt_ok) begin
                    if (s_q == 2'b01 && prev_f_q == 2'b00) begin
                        state_d = StLocked;
                        run_d   = '0;
                    end else begin
                        prev_f_d = s_q;
                        if (tries_q == TriesMax) begin
                            state_d = StFail;
                        end else begin
                            state_d = StStop;
                            cnt_d   = '0;
                            tries_d = tries_inc;
                        end
                    end
                end
            end
            StStop: begin
                if (cnt_q == StopLast) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLocked: begin
`ifdef CLK_ALIGN_RELOCK_EN
                run_d = run_nxt;
                if (filt_ok && s_q != 2'b01) begin
                    state_d  = StStop;
                    cnt_d    = '0;
                    prev_f_d = 2'b11;
                    tries_d  = tries_inc;
                end
`endif
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StSettle;
                cnt_d   = '0;
            end
        endcase

        // Restart outranks any decision taken above in the same cycle.
        if (restart) begin
            state_d  = StSettle;
            cnt_d    = '0;
            run_d    = '0;
            prev_f_d = 2'b11;
            tries_d  = '0;
        end

        stop_d = (state_d == StStop);
        lock_d = (state_d == StLocked);
        fail_d = (state_d == StFail);
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q  <= StSettle;
            cnt_q    <= '0;
            run_q    <= '0;
            s_q      <= '0;
            s_prev_q <= '0;
            prev_f_q <= 2'b11;
            tries_q  <= '0;
            stop_q   <= 1'b0;
            lock_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            s_q      <= align_status;
            s_prev_q <= s_q;
            prev_f_q <= prev_f_d;
            tries_q  <= tries_d;
            stop_q   <= stop_d;
            lock_q   <= lock_d;
            fail_q   <= fail_d;
        end
    end

    assign eclk_stop = stop_q;
    assign lock      = lock_q;
    assign fail      = fail_q;
    assign tries     = tries_q;

endmodule

// File: tb/tb_clk_align_fsm.sv
// Bench for clk_align_fsm: a timeline model predicts every output change, a monitor compares
// each observed change against the queued prediction.
module tb_clk_align_fsm;

    localparam int SETTLE = 16;
    localparam int FILT   = 8;
    localparam int STOPW  = 4;
    localparam int MAXT   = 15;
    localparam int NMAX   = 12000;

    logic       sclk;
    logic       reset;
    logic       restart;
    logic [1:0] align_status;
    logic       eclk_stop;
    logic       lock;
    logic       fail;
    logic [3:0] tries;

    clk_align_fsm #(
        .SETTLE_CYCLES(SETTLE),
        .FILTER_LEN   (FILT),
        .STOP_CYCLES  (STOPW),
        .MAX_TRIES    (MAXT)
    ) dut (
        .sclk        (sclk),
        .reset       (reset),
        .align_status(align_status),
        .restart     (restart),
        .eclk_stop   (eclk_stop),
        .lock        (lock),
        .fail        (fail),
        .tries       (tries)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } ev_t;

    typedef struct {
        int mode;
        int len;
        int rule;
        int kick;
        int hold;
    } seg_t;

    logic [1:0] a_arr    [NMAX];
    bit         kick_rst [NMAX];
    bit         kick_rs  [NMAX];
    logic [6:0] expv     [NMAX];
    ev_t        evq      [$];
    seg_t       plan     [$];
    int         n_edges;
    int         vectors;
    int         miscompares;

    // Expected output vector {eclk_stop, lock, fail, tries}.
    function automatic logic [6:0] pack(bit st, bit lk, bit fl, int tr);
        return {st, lk, fl, 4'(tr)};
    endfunction

    function automatic void fill(int from, int to, logic [6:0] v);
        for (int i = from; i < to; i++) expv[i] = v;
    endfunction

    // First edge k >= s+FILT-1 whose preceding FILT samples are identical.
    function automatic int find_window(int s, int en, bit skip01);
        bit same;
        for (int k = s + FILT - 1; k < en; k++) begin
            same = 1'b1;
            for (int j = k - FILT; j < k - 1; j++) begin
                if (a_arr[j] != a_arr[j+1]) same = 1'b0;
            end
            if (same && !(skip01 && a_arr[k-1] == 2'b01)) return k;
        end
        return en;
    endfunction

    // Outputs for edges st..en-1; sampling begins SETTLE edges after st.
    function automatic void model_seg(int st, int en);
        int         t;
        int         k;
        int         tr;
        logic [1:0] pf;
        logic [1:0] f;
        bit         done;
        pf   = 2'b11;
        tr   = 0;
        t    = st;
        done = 1'b0;
        fill(st, en, '0);
        while (!done) begin
            k = find_window(t + SETTLE, en, 1'b0);
            if (k >= en) begin
                done = 1'b1;
            end else begin
                f = a_arr[k-1];
                if (f == 2'b01 && pf == 2'b00) begin
                    fill(k, en, pack(1'b0, 1'b1, 1'b0, tr));
`ifdef CLK_ALIGN_RELOCK_EN
                    k = find_window(k + 1, en, 1'b1);
                    if (k >= en) begin
                        done = 1'b1;
                    end else begin
                        pf = 2'b11;
                        tr = (tr < 15) ? tr + 1 : 15;
                        fill(k, en, pack(1'b0, 1'b0, 1'b0, tr));
                        fill(k, (k + STOPW < en) ? k + STOPW : en, pack(1'b1, 1'b0, 1'b0, tr));
                        t = k + STOPW + 1;
                    end
`else
                    done = 1'b1;
`endif
                end else begin
                    pf = f;
                    if (tr == MAXT) begin
                        fill(k, en, pack(1'b0, 1'b0, 1'b1, tr));
                        done = 1'b1;
                    end else begin
                        tr++;
                        fill(k, en, pack(1'b0, 1'b0, 1'b0, tr));
                        fill(k, (k + STOPW < en) ? k + STOPW : en, pack(1'b1, 1'b0, 1'b0, tr));
                        t = k + STOPW + 1;
                    end
                end
            end
        end
    endfunction

    function automatic void gen_stim(int mode, int from, int to);
        int         o;
        int         d;
        int         run;
        logic [1:0] v;
        d   = 30 + int'($urandom_range(0, 20));
        run = 0;
        v   = 2'b00;
        for (int i = from; i < to; i++) begin
            o = i - from;
            case (mode)
                0: a_arr[i] = (o < d) ? 2'b00 : 2'b01;
                1: a_arr[i] = 2'b01;
                2: a_arr[i] = ((o / 3) % 2 == 1) ? 2'b01 : 2'b00;
                3: begin
                    if (run == 0) begin
                        v   = 2'($urandom_range(0, 3));
                        run = int'($urandom_range(1, 24));
                    end
                    a_arr[i] = v;
                    run--;
                end
                default: a_arr[i] = (o < 40) ? 2'b00 : (o < 120) ? 2'b01 :
                                    (o < 140) ? 2'b10 : 2'b01;
            endcase
        end
    endfunction

    // Driver: build plan and model, then apply stimulus and queue predicted changes.
    initial begin
        seg_t sg;
        int   pos;
        int   st;
        int   en;
        int   p;
        int   want;
        int   seen;
        int   md;
        int   kk;
        // mode, len, end rule, kick at start (0 reset, 1 restart, 2 both), kick hold
        plan.push_back('{0, 300, 0, 0, 3});
        plan.push_back('{1, 600, 0, 1, 1});
        plan.push_back('{1, 600, 1, 0, 1});
        plan.push_back('{2, 200, 0, 1, 1});
        plan.push_back('{4, 300, 0, 1, 1});
        plan.push_back('{0, 300, 2, 1, 1});
        plan.push_back('{1, 300, 3, 1, 1});
        plan.push_back('{3, 400, 0, 0, 2});
        plan.push_back('{0, 300, 0, 2, 1});
        for (int r = 0; r < 6; r++) begin
            md = int'($urandom_range(0, 4));
            kk = int'($urandom_range(0, 2));
            plan.push_back('{md, 150 + int'($urandom_range(0, 350)), 0, kk,
                             (kk == 1) ? 1 : 1 + int'($urandom_range(0, 1))});
        end

        pos = 0;
        foreach (plan[n]) begin
            sg = plan[n];
            for (int j = pos; j < pos + sg.hold; j++) begin
                kick_rst[j] = (sg.kick != 1);
                kick_rs[j]  = (sg.kick != 0);
            end
            st = pos + sg.hold;
            en = st + sg.len;
            gen_stim(sg.mode, pos, en);
            fill(pos, st, '0);
            model_seg(st, en);
            if (sg.rule != 0) begin
                want = (sg.rule == 1) ? 3 : 1;
                seen = 0;
                p    = -1;
                for (int i = st + 1; i < en; i++) begin
                    if (p < 0 && expv[i][6] && !expv[i-1][6]) begin
                        seen++;
                        if (seen == want) p = i;
                    end
                end
                if (p > 0) begin
                    en = (sg.rule == 1) ? p + 2 : (sg.rule == 2) ? p : p + 1;
                    model_seg(st, en);
                end
            end
            pos = en;
        end
        n_edges = pos;

        for (int k = 0; k < n_edges; k++) begin
            if (k > 0) @(negedge sclk);
            reset        = kick_rst[k];
            restart      = kick_rs[k];
            align_status = a_arr[k];
            if (k > 0 && expv[k] != expv[k-1]) evq.push_back('{k, expv[k]});
        end
    end

    // Monitor: every output change must match the oldest queued prediction.
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        ev_t        e;
        vectors     = 0;
        miscompares = 0;
        prev        = '0;
        @(negedge sclk);
        for (int k = 0; k < n_edges; k++) begin
            if (k > 0) @(negedge sclk);
            cur = {eclk_stop, lock, fail, tries};
            if (k == 0) begin
                vectors++;
                if (cur !== 7'd0) begin
                    miscompares++;
                    $display("FAIL reset_state: got %b, want 0000000", cur);
                end
            end else if (cur !== prev) begin
                while (evq.size() > 0 && evq[0].cyc < k) begin
                    e = evq.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL missed_change @%0d: got %b, want %b", e.cyc, prev, e.val);
                end
                vectors++;
                if (evq.size() > 0 && evq[0].cyc == k) begin
                    e = evq.pop_front();
                    if (cur !== e.val) begin
                        miscompares++;
                        $display("FAIL output_change @%0d: got %b, want %b", k, cur, e.val);
                    end
                end else begin
                    miscompares++;
                    $display("FAIL unexpected_change @%0d: got %b, want %b", k, cur, prev);
                end
            end
            prev = cur;
        end
        while (evq.size() > 0) begin
            e = evq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_change @%0d: got %b, want %b", e.cyc, prev, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
